// File: rtl/uart_rx_axis.sv
// UART receiver with 16x oversampling, majority-vote bit sampling and an
// AXI-Stream output FIFO. tuser carries {parity_err, frame_err} per word.
module uart_rx_axis #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [1:0]           m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int OSR_DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW      = $clog2(OSR_DIV + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int EW      = DATA_BITS + 2;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t               state, state_nxt;
    logic                 rx_m, rx_s, rx_prev;
    logic [1:0]           sync_vld;
    logic                 start_edge;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [3:0]           tk;
    logic                 s7, s8, maj;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_idx;
    logic                 perr, ferr, done;
    logic                 push, pop, full, wr_en;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [CW-1:0]        count;
    logic [EW-1:0]        head;

    // Two-flop synchronizer; sync_vld marks when rx_s holds a real line value
    // rather than its reset value, so a line low at reset release is no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            rx_m     <= rx;
            rx_s     <= rx_m;
            rx_prev  <= sync_vld[1] ? rx_s : 1'b0;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    assign start_edge = rx_prev & ~rx_s;
    assign tick       = (div_cnt == DW'(OSR_DIV - 1));
    assign maj        = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

    // Oversample divider and tick-in-bit counter, both realigned on start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tk      <= '0;
        end else if (state == ST_IDLE && start_edge) begin
            div_cnt <= '0;
            tk      <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            tk      <= tk + 4'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic; bit boundaries fall on tick 15, decisions on tick 9
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_edge) state_nxt = ST_START;
            ST_START: begin
                if (tick && tk == 4'd9 && maj) state_nxt = ST_IDLE;
                else if (tick && tk == 4'd15)  state_nxt = ST_DATA;
            end
            ST_DATA:
                if (tick && tk == 4'd15 && bit_idx == 4'(DATA_BITS - 1))
                    state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick && tk == 4'd15) state_nxt = ST_STOP;
            ST_STOP:   if (done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and the FIFO push one clock after the last stop sample
    always_comb begin
        busy = (state != ST_IDLE);
        push = (state == ST_STOP) && done;
    end

    // Frame datapath: majority samples, shift register, error flags, bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s7      <= 1'b1;
            s8      <= 1'b1;
            shreg   <= '0;
            bit_idx <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            done    <= 1'b0;
        end else if (state == ST_IDLE) begin
            bit_idx <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            done    <= 1'b0;
        end else if (tick) begin
            if (tk == 4'd7) s7 <= rx_s;
            if (tk == 4'd8) s8 <= rx_s;
            case (state)
                ST_DATA: begin
                    if (tk == 4'd9) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (tk == 4'd15)
                        bit_idx <= (bit_idx == 4'(DATA_BITS - 1)) ? 4'd0 : bit_idx + 4'd1;
                end
                ST_PARITY:
                    if (tk == 4'd9)
                        perr <= (PARITY == 1) ? (^shreg ^ maj) : ~(^shreg ^ maj);
                ST_STOP: begin
                    if (tk == 4'd9) begin
                        if (!maj) ferr <= 1'b1;
                        if (bit_idx == 4'(STOP_BITS - 1)) done <= 1'b1;
                    end
                    if (tk == 4'd15) bit_idx <= bit_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign pop   = m_axis_tvalid && m_axis_tready;
    assign full  = (count == CW'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    // FIFO storage; no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= {ferr, perr, shreg};
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_en) wptr <= wptr + AW'(1);
            if (pop)   rptr <= rptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry is masked when empty so outputs read zero out of reset
    assign m_axis_tvalid = (count != '0);
    assign head          = m_axis_tvalid ? mem[rptr] : '0;
    assign m_axis_tdata  = head[DATA_BITS-1:0];
    assign m_axis_tuser  = {head[DATA_BITS], head[DATA_BITS+1]};

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: dut0 without parity, dut1 with even parity.
// Expected beats go into per-DUT queues and are checked as they leave the FIFO.
module tb_uart_rx_axis;

    localparam int BT = 64;   // clocks per bit at OSR_DIV=4

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1, tready0, tready1;
    logic [7:0] tdata0, tdata1;
    logic [1:0] tuser0, tuser1;
    logic       tvalid0, tvalid1, ovr0, ovr1, busy0, busy1;

    int total = 0;
    int bad   = 0;
    int beats0 = 0, beats1 = 0, ovr0_cnt = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] exp_v;
    logic       hold0;
    logic [9:0] hold_v0;

    uart_rx_axis #(.CLK_FREQ(7_372_800), .BAUD(115200), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .m_axis_tdata(tdata0), .m_axis_tuser(tuser0),
        .m_axis_tvalid(tvalid0), .m_axis_tready(tready0), .overrun(ovr0), .busy(busy0));

    uart_rx_axis #(.CLK_FREQ(7_372_800), .BAUD(115200), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .m_axis_tdata(tdata1), .m_axis_tuser(tuser1),
        .m_axis_tvalid(tvalid1), .m_axis_tready(tready1), .overrun(ovr1), .busy(busy1));

    always #5 clk = ~clk;

    // Scoreboard: compare every accepted beat with the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (ovr0) ovr0_cnt++;
            if (hold0) begin
                total++;
                if ({tuser0, tdata0} !== hold_v0) begin
                    bad++;
                    $display("FAIL hold0: got %h, required stable %h", {tuser0, tdata0}, hold_v0);
                end
            end
            hold0   <= tvalid0 && !tready0;
            hold_v0 <= {tuser0, tdata0};
            if (tvalid0 && tready0) begin
                total++;
                beats0++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL beat0: unexpected beat %h, required none", {tuser0, tdata0});
                end else begin
                    exp_v = q0.pop_front();
                    if ({tuser0, tdata0} !== exp_v) begin
                        bad++;
                        $display("FAIL beat0: got %h, required %h", {tuser0, tdata0}, exp_v);
                    end
                end
            end
            if (tvalid1 && tready1) begin
                total++;
                beats1++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL beat1: unexpected beat %h, required none", {tuser1, tdata1});
                end else begin
                    exp_v = q1.pop_front();
                    if ({tuser1, tdata1} !== exp_v) begin
                        bad++;
                        $display("FAIL beat1: got %h, required %h", {tuser1, tdata1}, exp_v);
                    end
                end
            end
        end else begin
            hold0 <= 1'b0;
        end
    end

    // Safety net against a hung run
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) rx0 = v; else rx1 = v;
        cyc(n);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                              input logic pbit, input logic stop);
        drive(sel, 1'b0, BT);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BT);
        if (use_par) drive(sel, pbit, BT);
        drive(sel, stop, BT);
        drive(sel, 1'b1, BT);
    endtask

    task automatic wait_empty(input int sel);
        int n = 0;
        while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL drain%0d: %0d beats missing, required 0", sel,
                     (sel == 0) ? q0.size() : q1.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        total++;
        if ({tvalid0, tdata0, tuser0, ovr0, busy0} !== 13'd0) begin
            bad++;
            $display("FAIL reset0: got %b, required 0", {tvalid0, tdata0, tuser0, ovr0, busy0});
        end
        total++;
        if ({tvalid1, tdata1, tuser1, ovr1, busy1} !== 13'd0) begin
            bad++;
            $display("FAIL reset1: got %b, required 0", {tvalid1, tdata1, tuser1, ovr1, busy1});
        end
        rst = 1'b0;
        cyc(10);
    endtask

    task automatic test_basic;
        int o = ovr0_cnt;
        q0.push_back({2'b00, 8'hA5});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_empty(0);
        total++;
        if (ovr0_cnt != o) begin
            bad++;
            $display("FAIL basic_ovr: got %0d pulses, required 0", ovr0_cnt - o);
        end
    endtask

    task automatic test_latency;
        logic [7:0] d = 8'h5A;
        tready0 = 1'b0;
        q0.push_back({2'b00, 8'h5A});
        drive(0, 1'b0, BT);
        for (int i = 0; i < 8; i++) drive(0, d[i], BT);
        drive(0, 1'b1, 30);
        total++;
        if (tvalid0 !== 1'b0) begin
            bad++;
            $display("FAIL early_push: tvalid got %b, required 0", tvalid0);
        end
        cyc(18);
        total++;
        if (tvalid0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL stop_push: tvalid/busy got %b%b, required 10", tvalid0, busy0);
        end
        cyc(40);
        total++;
        if ({tuser0, tdata0} !== {2'b00, 8'h5A}) begin
            bad++;
            $display("FAIL held_head: got %h, required 05a", {tuser0, tdata0});
        end
        tready0 = 1'b1;
        wait_empty(0);
    endtask

    task automatic test_parity;
        q1.push_back({2'b10, 8'h07});
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        q1.push_back({2'b00, 8'h07});
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        q1.push_back({2'b00, 8'hC3});
        send_frame(1, 8'hC3, 1'b1, 1'b0, 1'b1);
        wait_empty(1);
    endtask

    task automatic test_break;
        int b;
        q0.push_back({2'b01, 8'h3C});
        drive(0, 1'b0, BT);
        for (int i = 0; i < 8; i++) drive(0, (8'h3C >> i) & 1'b1, BT);
        drive(0, 1'b0, BT);
        wait_empty(0);
        b = beats0;
        drive(0, 1'b0, 3 * BT);
        total++;
        if (beats0 != b || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL break_retrig: extra beats %0d busy %b, required 0 0", beats0 - b, busy0);
        end
        drive(0, 1'b1, BT);
        q0.push_back({2'b00, 8'h11});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_empty(0);
    endtask

    task automatic test_false_start;
        int b = beats0;
        int n = 0;
        drive(0, 1'b0, 8);
        rx0 = 1'b1;
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("FAIL fs_busy: got %b, required 1", busy0);
        end
        while (busy0 !== 1'b0 && n < BT) begin
            cyc(1);
            n++;
        end
        total++;
        if (n >= BT) begin
            bad++;
            $display("FAIL fs_idle: busy still %b after %0d clocks, required 0", busy0, n);
        end
        cyc(4 * BT);
        total++;
        if (beats0 != b || tvalid0 !== 1'b0) begin
            bad++;
            $display("FAIL fs_beat: got %0d beats, required 0", beats0 - b);
        end
    endtask

    task automatic test_overrun;
        int o = ovr0_cnt;
        int b = beats0;
        tready0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) q0.push_back({2'b00, 8'(k)});
            send_frame(0, 8'(k), 1'b0, 1'b0, 1'b1);
        end
        total++;
        if (ovr0_cnt - o != 1) begin
            bad++;
            $display("FAIL ovr_count: got %0d pulses, required 1", ovr0_cnt - o);
        end
        total++;
        if (tdata0 !== 8'h01 || tvalid0 !== 1'b1) begin
            bad++;
            $display("FAIL ovr_head: got %h valid %b, required 01 1", tdata0, tvalid0);
        end
        tready0 = 1'b1;
        wait_empty(0);
        cyc(10);
        total++;
        if (beats0 - b != 4) begin
            bad++;
            $display("FAIL ovr_beats: got %0d, required 4", beats0 - b);
        end
    endtask

    task automatic test_reset_mid;
        int b;
        drive(0, 1'b0, BT);
        drive(0, 1'b1, BT);
        drive(0, 1'b0, 20);
        rst = 1'b1;
        cyc(2);
        total++;
        if ({tvalid0, tdata0, tuser0, ovr0, busy0} !== 13'd0) begin
            bad++;
            $display("FAIL mid_reset: got %b, required 0", {tvalid0, tdata0, tuser0, ovr0, busy0});
        end
        cyc(5);
        rst = 1'b0;
        b = beats0;
        cyc(100);
        total++;
        if (busy0 !== 1'b0) begin
            bad++;
            $display("FAIL low_release: busy got %b, required 0", busy0);
        end
        drive(0, 1'b1, BT);
        q0.push_back({2'b00, 8'h9A});
        send_frame(0, 8'h9A, 1'b0, 1'b0, 1'b1);
        wait_empty(0);
        cyc(10);
        total++;
        if (beats0 - b != 1) begin
            bad++;
            $display("FAIL mid_beats: got %0d, required 1", beats0 - b);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        tready0 = 1'b1;
        tready1 = 1'b1;
        test_reset;
        test_basic;
        test_latency;
        test_parity;
        test_break;
        test_false_start;
        test_overrun;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis.md
UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL provide parameter DATA_BITS, default 8, legal range 5..9, data bits per frame.
REQ-004 SHALL provide parameter PARITY, default 0, 0=none, 1=even, 2=odd.
REQ-005 SHALL provide parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL provide parameter FIFO_DEPTH, default 4, a power of two >= 2, output FIFO entries.
REQ-007 SHALL provide port clk, input, 1 bit, clock; all logic on its rising edge.
REQ-008 SHALL provide port rst, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL provide port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-010 SHALL provide port m_axis_tdata, output, DATA_BITS bits, received word.
REQ-011 SHALL provide port m_axis_tuser, output, 2 bits, {parity_err, frame_err} for the word.
REQ-012 SHALL provide port m_axis_tvalid, output, 1 bit, FIFO not empty.
REQ-013 SHALL provide port m_axis_tready, input, 1 bit, downstream accept.
REQ-014 SHALL provide port overrun, output, 1 bit, one-cycle pulse when a frame is dropped.
REQ-015 SHALL provide port busy, output, 1 bit, high while the FSM is not in IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer (rx_s); all sampling uses rx_s only.
REQ-017 SHALL generate an oversample tick every OSR_DIV = CLK_FREQ/(BAUD*16) clocks; the tick counter restarts at 0 on start detection.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-019 IDLE: SHALL detect start on a 1->0 transition of rx_s only; a line held low (break) never re-triggers.
REQ-020 Each bit period is 16 ticks; the bit value SHALL be the majority of rx_s at ticks 7, 8, 9.
REQ-021 START: a majority of 1 SHALL be a false start -> return to IDLE with no output and no flags.
REQ-022 DATA: SHALL shift DATA_BITS bits LSB first, then go to PARITY or STOP.
REQ-023 PARITY: parity_err SHALL be set when the XOR of the data bits and the parity bit is 1 (even) or 0 (odd).
REQ-024 STOP: frame_err SHALL be set if any stop-bit majority is 0; both stop bits are checked when STOP_BITS=2.
REQ-025 SHALL push {frame_err, parity_err, data} into the FIFO and return to IDLE on the clock after the tick-9 sample of the last stop bit; it shall not wait out the rest of the stop bit.
REQ-026 The FIFO SHALL pop on m_axis_tvalid && m_axis_tready; tdata/tuser show the head entry and stay stable while tvalid && !tready.
REQ-027 Latency: with the FIFO empty, m_axis_tvalid SHALL rise exactly 1 clock after the push.
REQ-028 On a push with the FIFO full and no pop that cycle, SHALL drop the new frame, keep the existing contents and pulse overrun for 1 clock.
REQ-029 On a push and pop in the same cycle while full, SHALL accept the push with no overrun.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count is $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-031 While rst is high: FSM=IDLE, FIFO empty, synchronizer flops=1; m_axis_tvalid, m_axis_tdata, m_axis_tuser, overrun, busy all =0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release, start detection needs a fresh 1->0 edge.

Verification (CLK_FREQ=7_372_800, BAUD=115200, OSR_DIV=4)
REQ-033 PARITY=0, send 0xA5, tready=1 -> one beat, tdata=0xA5, tuser=2'b00, overrun never high.
REQ-034 PARITY=1, send 0x07 with parity bit 0 -> tdata=0x07, tuser=2'b10.
REQ-035 Send 0x3C with stop bit 0, then line low 3 bit periods -> tdata=0x3C, tuser=2'b01; no further beats until a new 1->0 edge.
REQ-036 rx low for 8 clocks (2 ticks), then high -> no beat; busy returns to 0 in the START check.
REQ-037 tready=0, send 0x01..0x05 (FIFO_DEPTH=4) -> overrun pulses once on the 5th frame; set tready=1 -> beats 0x01, 0x02, 0x03, 0x04 in order.
REQ-038 Assert rst mid-data of 0x55, release, send 0x9A -> all outputs 0 during reset; exactly one beat, tdata=0x9A.
